watch_ctrl: RTL and testbench
=============================

# watch_ctrl

Control sequencer for the stopwatch: converts the debounced button levels and slider-switch settings into the command signals consumed by the time counter. It is the initiator of the counter's command interface: count enable, clear and digit-load strobes. It also produces the digit blink mask for the display. It sits between the debounce/switch inputs and the counter/display in the top level.

## Interface
- SEC_TENS_MAX, 5, largest legal value loaded into the seconds-tens digit
- MIN_TENS_MAX, 5, largest legal value loaded into the minutes-tens digit
- UNITS_MAX, 9, largest legal value loaded into either units digit

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- btn_reset  in  1  debounced reset button level
- btn_pause  in  1  debounced start/pause button level
- adj  in  1  adjust-mode switch level
- sel  in  2  digit select: 0=sec_r, 1=sec_l, 2=min_r, 3=min_l
- num  in  4  binary value to load into the selected digit
- tick_blink  in  1  one-cycle pulse at the blink rate (from clkdiv, 5 Hz)
- run  out  1  counter count enable
- clr  out  1  one-cycle pulse that zeroes all counter digits
- load  out  1  one-cycle digit-load strobe
- load_sel  out  2  digit written by load
- load_val  out  4  clamped digit value written by load
- blink_mask  out  4  one bit per digit (same index as sel); 1 blanks that digit

## Operation
- States: IDLE (stopped/paused), RUNNING, ADJUST. Reset state: IDLE.
- Edge detection:
  - btn_reset and btn_pause each pass through a history flop that resets to 0.
  - press = level & ~history.
  - A button held high through reset release therefore counts as one press.
- IDLE:
  - pause press -> RUNNING.
  - adj=1 -> ADJUST.
- RUNNING:
  - pause press -> IDLE.
  - adj=1 -> ADJUST.
- ADJUST:
  - adj=0 -> IDLE.
  - Pause presses are ignored.
- adj=1 has priority over a pause press in the same cycle. The state goes to ADJUST and the press is discarded.
- run=1 only in RUNNING.
- Reset press, in any state: clr pulses high one cycle. The state is unchanged, so a running stopwatch restarts from 0.
- Reset press and pause press in the same cycle: both take effect.
- Load generation, in ADJUST only:
  - A load pulse is issued on entry to ADJUST.
  - A load pulse is also issued in every ADJUST cycle where sel or num differs from its registered previous value.
  - load_sel = sel.
  - load_val = num clamped to the digit maximum: UNITS_MAX for sel 0/2, SEC_TENS_MAX for sel 1, MIN_TENS_MAX for sel 3. Examples: num=12 on sel 0 -> 9; num=7 on sel 3 -> 5.
  - load_sel and load_val hold their last values when load=0.
- clr and load in the same cycle: both asserted. The counter applies clr first, then load.
- Blink:
  - A phase flop toggles on each tick_blink while in ADJUST.
  - The phase is forced to 1 on ADJUST entry.
  - blink_mask = onehot(sel) when phase=0, else 0.
  - blink_mask = 0 outside ADJUST.
- Counter arithmetic and digit storage are not part of this block.

## Timing
- All outputs are registered.
- Reset values: run=0, clr=0, load=0, load_sel=0, load_val=0, blink_mask=0, state=IDLE, blink phase=1, history flops=0.
- Button press latency: level rises before edge N -> state/clr updated at edge N+1. The press is detected at N (history updates at N) and the outputs register at N+1.
- adj latency: adj=1 sampled at edge N -> run=0, first load pulse, and ADJUST from edge N+1.
- sel/num latency: a change sampled at edge N -> load pulse in the cycle after edge N+1. The pulse carries the new clamped value.
- blink_mask: follows a tick_blink at edge N by one cycle. It tracks sel changes with one cycle of latency.
- clr and load are exactly one cycle wide. A button held high produces only one pulse.
- Asserting rst mid-operation forces all reset values immediately. There is no pulse on release unless a button is held (see edge detection).

## Test plan
- Reset release with all inputs 0 -> all outputs 0, IDLE. A pause press -> run=1 two edges later. A second press -> run=0.
- RUNNING with btn_reset and btn_pause rising in the same cycle -> a single clr pulse and run drops to 0. Holding both high for 100 cycles gives no further pulses.
- adj=1 with sel=3, num=7 -> load pulse with load_sel=3, load_val=5. Then num=2 -> a second load pulse with value 2. Holding the inputs steady gives no more loads.
- ADJUST with sel=0, num=15 -> load_val=9. sel=1 -> load_val=5 (clamped). Pause presses leave run=0 and the state in ADJUST.
- ADJUST with sel=2 and three tick_blink pulses -> blink_mask sequence 0000 -> 0100 -> 0000 -> 0100. adj=0 -> mask 0000, IDLE, run=0.
- Assert rst while RUNNING in the middle of a load/clr pulse -> outputs zero immediately. Releasing rst with btn_pause held high -> one press is seen and run=1.

Source files
------------

// File: rtl/watch_ctrl.sv
// Stopwatch control sequencer: turns button/switch levels into run, clear and
// digit-load commands for the time counter, plus the display blink mask.
module watch_ctrl #(
    parameter int unsigned SEC_TENS_MAX = 5,
    parameter int unsigned MIN_TENS_MAX = 5,
    parameter int unsigned UNITS_MAX    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_reset,
    input  logic       btn_pause,
    input  logic       adj,
    input  logic [1:0] sel,
    input  logic [3:0] num,
    input  logic       tick_blink,
    output logic       run,
    output logic       clr,
    output logic       load,
    output logic [1:0] load_sel,
    output logic [3:0] load_val,
    output logic [3:0] blink_mask
);

    localparam logic [3:0] SEC_TENS_LIM = 4'(SEC_TENS_MAX);
    localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_TENS_MAX);
    localparam logic [3:0] UNITS_LIM    = 4'(UNITS_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        ADJUST  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       rst_hist_q, rst_hist_d;
    logic       pause_hist_q, pause_hist_d;
    logic       rst_press_q, rst_press_d;
    logic       pause_press_q, pause_press_d;
    logic       adj_q, adj_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] num_q, num_d;
    logic       tick_q, tick_d;
    logic [1:0] sel_prev_q, sel_prev_d;
    logic [3:0] num_prev_q, num_prev_d;
    logic       phase_q, phase_d;
    logic       run_q, run_d;
    logic       clr_q, clr_d;
    logic       load_q, load_d;
    logic [1:0] load_sel_q, load_sel_d;
    logic [3:0] load_val_q, load_val_d;
    logic [3:0] blink_mask_q, blink_mask_d;

    logic [3:0] digit_max;
    logic [3:0] clamped_num;
    logic       entering_adjust;

    // Inputs are sampled once so every decision below sees a stable, registered view.
    always_comb begin
        rst_hist_d    = btn_reset;
        pause_hist_d  = btn_pause;
        rst_press_d   = btn_reset & ~rst_hist_q;
        pause_press_d = btn_pause & ~pause_hist_q;
        adj_d         = adj;
        sel_d         = sel;
        num_d         = num;
        tick_d        = tick_blink;
        sel_prev_d    = sel_q;
        num_prev_d    = num_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (adj_q)              state_d = ADJUST;
                else if (pause_press_q) state_d = RUNNING;
            end
            RUNNING: begin
                if (adj_q)              state_d = ADJUST;
                else if (pause_press_q) state_d = IDLE;
            end
            ADJUST: begin
                if (!adj_q)             state_d = IDLE;
            end
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        digit_max = UNITS_LIM;
        unique case (sel_q)
            2'd1:    digit_max = SEC_TENS_LIM;
            2'd3:    digit_max = MIN_TENS_LIM;
            default: digit_max = UNITS_LIM;
        endcase
        clamped_num = (num_q > digit_max) ? digit_max : num_q;
    end

    // Load fires on ADJUST entry and whenever the sampled digit select or value moves.
    always_comb begin
        entering_adjust = (state_d == ADJUST) && (state_q != ADJUST);
        run_d           = (state_d == RUNNING);
        clr_d           = rst_press_q;
        load_d          = (state_d == ADJUST) &&
                          (entering_adjust || (sel_q != sel_prev_q) || (num_q != num_prev_q));
        load_sel_d      = load_d ? sel_q : load_sel_q;
        load_val_d      = load_d ? clamped_num : load_val_q;

        phase_d = phase_q;
        if (entering_adjust)
            phase_d = 1'b1;
        else if ((state_q == ADJUST) && tick_q)
            phase_d = ~phase_q;

        blink_mask_d = 4'b0000;
        if ((state_d == ADJUST) && !phase_d)
            blink_mask_d = 4'b0001 << sel_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rst_hist_q    <= 1'b0;
            pause_hist_q  <= 1'b0;
            rst_press_q   <= 1'b0;
            pause_press_q <= 1'b0;
            adj_q         <= 1'b0;
            sel_q         <= 2'd0;
            num_q         <= 4'd0;
            tick_q        <= 1'b0;
            sel_prev_q    <= 2'd0;
            num_prev_q    <= 4'd0;
            phase_q       <= 1'b1;
            run_q         <= 1'b0;
            clr_q         <= 1'b0;
            load_q        <= 1'b0;
            load_sel_q    <= 2'd0;
            load_val_q    <= 4'd0;
            blink_mask_q  <= 4'd0;
        end else begin
            state_q       <= state_d;
            rst_hist_q    <= rst_hist_d;
            pause_hist_q  <= pause_hist_d;
            rst_press_q   <= rst_press_d;
            pause_press_q <= pause_press_d;
            adj_q         <= adj_d;
            sel_q         <= sel_d;
            num_q         <= num_d;
            tick_q        <= tick_d;
            sel_prev_q    <= sel_prev_d;
            num_prev_q    <= num_prev_d;
            phase_q       <= phase_d;
            run_q         <= run_d;
            clr_q         <= clr_d;
            load_q        <= load_d;
            load_sel_q    <= load_sel_d;
            load_val_q    <= load_val_d;
            blink_mask_q  <= blink_mask_d;
        end
    end

    assign run        = run_q;
    assign clr        = clr_q;
    assign load       = load_q;
    assign load_sel   = load_sel_q;
    assign load_val   = load_val_q;
    assign blink_mask = blink_mask_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed testbench for watch_ctrl: inputs change on the falling edge and
// outputs are sampled on a later falling edge, away from the active edge.
module tb_watch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_reset;
    logic       btn_pause;
    logic       adj;
    logic [1:0] sel;
    logic [3:0] num;
    logic       tick_blink;
    logic       run;
    logic       clr;
    logic       load;
    logic [1:0] load_sel;
    logic [3:0] load_val;
    logic [3:0] blink_mask;

    int checks   = 0;
    int failures = 0;

    watch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_reset  (btn_reset),
        .btn_pause  (btn_pause),
        .adj        (adj),
        .sel        (sel),
        .num        (num),
        .tick_blink (tick_blink),
        .run        (run),
        .clr        (clr),
        .load       (load),
        .load_sel   (load_sel),
        .load_val   (load_val),
        .blink_mask (blink_mask)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".run"}, 32'(run), 0);
        checkOutput({tag, ".clr"}, 32'(clr), 0);
        checkOutput({tag, ".load"}, 32'(load), 0);
        checkOutput({tag, ".load_sel"}, 32'(load_sel), 0);
        checkOutput({tag, ".load_val"}, 32'(load_val), 0);
        checkOutput({tag, ".blink_mask"}, 32'(blink_mask), 0);
    endtask

    task automatic applyStimulus(input logic b_rst, input logic b_pause, input logic a,
                                 input logic [1:0] s, input logic [3:0] n);
        btn_reset = b_rst;
        btn_pause = b_pause;
        adj       = a;
        sel       = s;
        num       = n;
    endtask

    task automatic pulseTick();
        tick_blink = 1'b1;
        step(1);
        tick_blink = 1'b0;
        step(1);
    endtask

    initial begin
        int clr_count;
        int load_count;
        rst        = 1'b0;
        tick_blink = 1'b0;
        applyStimulus(0, 0, 0, 2'd0, 4'd0);
        step(3);
        checkAllZero("in_reset");
        rst = 1'b1;
        step(2);
        checkAllZero("after_release");

        // Pause press: run two edges later, toggles off on a second press
        applyStimulus(0, 1, 0, 2'd0, 4'd0);
        step(1);
        checkOutput("press_latency_run", 32'(run), 0);
        step(1);
        checkOutput("press_run_on", 32'(run), 1);
        applyStimulus(0, 0, 0, 2'd0, 4'd0);
        step(3);
        checkOutput("run_holds", 32'(run), 1);
        applyStimulus(0, 1, 0, 2'd0, 4'd0);
        step(2);
        checkOutput("press_run_off", 32'(run), 0);
        applyStimulus(0, 0, 0, 2'd0, 4'd0);
        step(2);
        applyStimulus(0, 1, 0, 2'd0, 4'd0);
        step(2);
        checkOutput("rerun", 32'(run), 1);
        applyStimulus(0, 0, 0, 2'd0, 4'd0);
        step(2);

        // Reset and pause pressed together while running
        applyStimulus(1, 1, 0, 2'd0, 4'd0);
        step(2);
        checkOutput("both_clr", 32'(clr), 1);
        checkOutput("both_run", 32'(run), 0);
        step(1);
        checkOutput("clr_one_cycle", 32'(clr), 0);
        clr_count = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (clr) clr_count++;
        end
        checkOutput("held_no_clr", 32'(clr_count), 0);
        checkOutput("held_run", 32'(run), 0);
        applyStimulus(0, 0, 0, 2'd0, 4'd0);
        step(2);

        // Reset press alone keeps the stopwatch running
        applyStimulus(0, 1, 0, 2'd0, 4'd0);
        step(2);
        applyStimulus(0, 0, 0, 2'd0, 4'd0);
        step(1);
        applyStimulus(1, 0, 0, 2'd0, 4'd0);
        step(2);
        checkOutput("run_clr", 32'(clr), 1);
        checkOutput("run_clr_run", 32'(run), 1);
        applyStimulus(0, 0, 0, 2'd0, 4'd0);
        step(2);

        // Adjust entry from RUNNING with min_l clamp
        applyStimulus(0, 0, 1, 2'd3, 4'd7);
        step(1);
        checkOutput("adj_latency_run", 32'(run), 1);
        step(1);
        checkOutput("adj_run", 32'(run), 0);
        checkOutput("entry_load", 32'(load), 1);
        checkOutput("entry_sel", 32'(load_sel), 3);
        checkOutput("entry_val", 32'(load_val), 5);
        step(1);
        checkOutput("entry_load_end", 32'(load), 0);
        checkOutput("val_held", 32'(load_val), 5);
        applyStimulus(0, 0, 1, 2'd3, 4'd2);
        step(1);
        checkOutput("num_latency", 32'(load), 0);
        step(1);
        checkOutput("num_load", 32'(load), 1);
        checkOutput("num_val", 32'(load_val), 2);
        load_count = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (load) load_count++;
        end
        checkOutput("steady_no_load", 32'(load_count), 0);

        // Clamping per digit
        applyStimulus(0, 0, 1, 2'd0, 4'd15);
        step(2);
        checkOutput("sec_r_sel", 32'(load_sel), 0);
        checkOutput("sec_r_val", 32'(load_val), 9);
        step(1);
        applyStimulus(0, 0, 1, 2'd1, 4'd15);
        step(2);
        checkOutput("sec_l_load", 32'(load), 1);
        checkOutput("sec_l_val", 32'(load_val), 5);
        step(1);
        applyStimulus(0, 0, 1, 2'd2, 4'd12);
        step(2);
        checkOutput("min_r_val", 32'(load_val), 9);
        step(1);

        // Pause presses ignored in ADJUST
        applyStimulus(0, 1, 1, 2'd2, 4'd12);
        step(3);
        checkOutput("adj_pause_run", 32'(run), 0);
        applyStimulus(0, 0, 1, 2'd2, 4'd3);
        step(2);
        checkOutput("still_adjust_load", 32'(load), 1);
        checkOutput("still_adjust_val", 32'(load_val), 3);
        step(1);

        // Blink sequence on a fresh ADJUST entry with sel=2
        applyStimulus(0, 0, 0, 2'd2, 4'd3);
        step(2);
        checkOutput("exit_mask", 32'(blink_mask), 0);
        applyStimulus(0, 0, 1, 2'd2, 4'd3);
        step(2);
        checkOutput("blink_entry", 32'(blink_mask), 4'b0000);
        pulseTick();
        checkOutput("blink_t1", 32'(blink_mask), 4'b0100);
        pulseTick();
        checkOutput("blink_t2", 32'(blink_mask), 4'b0000);
        pulseTick();
        checkOutput("blink_t3", 32'(blink_mask), 4'b0100);
        applyStimulus(0, 0, 1, 2'd1, 4'd3);
        step(2);
        checkOutput("blink_sel_track", 32'(blink_mask), 4'b0010);
        applyStimulus(0, 0, 0, 2'd1, 4'd3);
        step(1);
        checkOutput("blink_exit_latency", 32'(blink_mask), 4'b0010);
        step(1);
        checkOutput("blink_exit_mask", 32'(blink_mask), 4'b0000);
        checkOutput("blink_exit_run", 32'(run), 0);

        // Back in IDLE: a press starts running, another stops it
        applyStimulus(0, 1, 0, 2'd1, 4'd3);
        step(2);
        checkOutput("idle_after_adj", 32'(run), 1);
        applyStimulus(0, 0, 0, 2'd1, 4'd3);
        step(1);
        applyStimulus(0, 1, 0, 2'd1, 4'd3);
        step(2);
        applyStimulus(0, 0, 0, 2'd1, 4'd3);
        step(2);

        // adj beats a simultaneous pause press from IDLE; the press is discarded
        applyStimulus(0, 1, 1, 2'd1, 4'd3);
        step(2);
        checkOutput("prio_run", 32'(run), 0);
        checkOutput("prio_load", 32'(load), 1);
        applyStimulus(0, 0, 0, 2'd1, 4'd3);
        step(3);
        checkOutput("prio_discarded", 32'(run), 0);

        // Reset asserted mid clr pulse while running
        applyStimulus(0, 1, 0, 2'd1, 4'd3);
        step(2);
        applyStimulus(0, 0, 0, 2'd1, 4'd3);
        step(1);
        applyStimulus(1, 0, 0, 2'd1, 4'd3);
        step(2);
        checkOutput("pre_rst_clr", 32'(clr), 1);
        checkOutput("pre_rst_run", 32'(run), 1);
        rst = 1'b0;
        #1;
        checkAllZero("async_rst");
        applyStimulus(0, 1, 0, 2'd0, 4'd0);
        step(2);
        rst = 1'b1;
        step(1);
        checkOutput("held_release_latency", 32'(run), 0);
        step(1);
        checkOutput("held_release_run", 32'(run), 1);
        checkOutput("held_release_clr", 32'(clr), 0);
        applyStimulus(0, 0, 0, 2'd0, 4'd0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
